// File: rtl/hazard_pkg.sv
// Shared hazard-unit types: stage slot layout, tnew/tuse constants, forward-select
// encodings and the small comparison helpers used by the hazard controller.
package hazard_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_NOW  = 2'd0;

  // D-stage forward selects
  localparam logic [1:0] FWD_D_GRF = 2'd0;
  localparam logic [1:0] FWD_D_E   = 2'd1;
  localparam logic [1:0] FWD_D_M   = 2'd2;

  // E-stage forward selects
  localparam logic [1:0] FWD_E_REG = 2'd0;
  localparam logic [1:0] FWD_E_M   = 2'd1;
  localparam logic [1:0] FWD_E_W   = 2'd2;

  // M-stage store-data select
  localparam logic FWD_M_REG = 1'b0;
  localparam logic FWD_M_W   = 1'b1;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == TNEW_NOW) ? TNEW_NOW : t - 2'd1;
  endfunction

  // Register 0 is hard-wired, so it never produces a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] a3);
    return (src != 5'd0) && (src == a3);
  endfunction

  function automatic logic [1:0] fwd_d_sel(input logic [4:0] src, input slot_t e,
                                           input slot_t m);
    if (reg_match(src, e.a3) && e.tnew == TNEW_NOW) return FWD_D_E;
    if (reg_match(src, m.a3) && m.tnew == TNEW_NOW) return FWD_D_M;
    return FWD_D_GRF;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [4:0] src, input slot_t m,
                                           input slot_t w);
    if (reg_match(src, m.a3) && m.tnew == TNEW_NOW) return FWD_E_M;
    if (reg_match(src, w.a3)) return FWD_E_W;
    return FWD_E_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage operand/destination info into the hazard unit and stall/forward selects out.
interface hazard_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_a3;
  logic [1:0] d_tnew;
  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       fwd_m_rt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );
endinterface

// File: rtl/hazard_stage_slot.sv
// One pipeline bookkeeping slot {rs, rt, a3, tnew}; optionally ages tnew by one
// (saturating at 0) as the instruction moves into this stage.
module hazard_stage_slot
  import hazard_pkg::*;
#(
  parameter bit DEC_TNEW = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  input  slot_t d,
  output slot_t q
);

  slot_t nxt;

  always_comb begin
    nxt = d;
    if (DEC_TNEW) nxt.tnew = tnew_dec(d.tnew);
  end

  // NOTE: non-blocking so E, M and W all shift on the same edge without ordering races.
  always_ff @(posedge clk) begin
    if (reset) q <= SLOT_BUBBLE;
    else       q <= nxt;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall detection plus D/E/M forward selects.
// Define HAZARD_FWD_EN to enable forwarding; otherwise selects are 0 and any hazard stalls.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  slot_t d_slot, e_d, e_q, m_q, w_q;
  logic  stall_raw;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic       fwd_m_rt;

  assign d_slot = '{rs: hz.d_rs, rt: hz.d_rt, a3: hz.d_a3, tnew: hz.d_tnew};
  assign e_d    = stall_raw ? SLOT_BUBBLE : d_slot;

  // E takes D's tnew as-is; aging starts on the E->M advance.
  hazard_stage_slot #(.DEC_TNEW(1'b0)) u_slot_e (.clk(clk), .reset(reset), .d(e_d), .q(e_q));
  hazard_stage_slot #(.DEC_TNEW(1'b1)) u_slot_m (.clk(clk), .reset(reset), .d(e_q), .q(m_q));
  hazard_stage_slot #(.DEC_TNEW(1'b1)) u_slot_w (.clk(clk), .reset(reset), .d(m_q), .q(w_q));

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    stall_raw = 1'b0;
    fwd_d_rs  = FWD_D_GRF;
    fwd_d_rt  = FWD_D_GRF;
    fwd_e_rs  = FWD_E_REG;
    fwd_e_rt  = FWD_E_REG;
    fwd_m_rt  = FWD_M_REG;
`ifdef HAZARD_FWD_EN
    stall_raw = (reg_match(hz.d_rs, e_q.a3) && (hz.d_tuse_rs < e_q.tnew)) ||
                (reg_match(hz.d_rs, m_q.a3) && (hz.d_tuse_rs < m_q.tnew)) ||
                (reg_match(hz.d_rt, e_q.a3) && (hz.d_tuse_rt < e_q.tnew)) ||
                (reg_match(hz.d_rt, m_q.a3) && (hz.d_tuse_rt < m_q.tnew));
    fwd_d_rs  = fwd_d_sel(hz.d_rs, e_q, m_q);
    fwd_d_rt  = fwd_d_sel(hz.d_rt, e_q, m_q);
    fwd_e_rs  = fwd_e_sel(e_q.rs, m_q, w_q);
    fwd_e_rt  = fwd_e_sel(e_q.rt, m_q, w_q);
    fwd_m_rt  = reg_match(m_q.rt, w_q.a3) ? FWD_M_W : FWD_M_REG;
`else
    stall_raw = reg_match(hz.d_rs, e_q.a3) || reg_match(hz.d_rs, m_q.a3) ||
                reg_match(hz.d_rt, e_q.a3) || reg_match(hz.d_rt, m_q.a3);
`endif
  end

  // Slots may still hold a hazard while reset is high; keep outputs quiet until they clear.
  assign hz.stall    = stall_raw & ~reset;
  assign hz.fwd_d_rs = reset ? FWD_D_GRF : fwd_d_rs;
  assign hz.fwd_d_rt = reset ? FWD_D_GRF : fwd_d_rt;
  assign hz.fwd_e_rs = reset ? FWD_E_REG : fwd_e_rs;
  assign hz.fwd_e_rt = reset ? FWD_E_REG : fwd_e_rt;
  assign hz.fwd_m_rt = reset ? FWD_M_REG : fwd_m_rt;

endmodule
